// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encoding, ALU op positions, func codes, divider states
// and the ID->EX bus layout for the SimpleCPU execute stage.
package ex_stage_pkg;

    localparam int STALL_WD     = 6;
    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_RF_WD  = 38;

    // Stall vector bit positions and encoding
    localparam int   STALL_EX  = 2;
    localparam int   STALL_MEM = 3;
    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;

    // One-hot alu_op bit positions (add is the MSB)
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MFHI     = 6'h10;
    localparam logic [5:0] FN_MTHI     = 6'h11;
    localparam logic [5:0] FN_MFLO     = 6'h12;
    localparam logic [5:0] FN_MTLO     = 6'h13;
    localparam logic [5:0] FN_DIV      = 6'h1A;
    localparam logic [5:0] FN_DIVU     = 6'h1B;

    localparam logic [1:0] DIV_ST_IDLE = 2'd0;
    localparam logic [1:0] DIV_ST_RUN  = 2'd1;
    localparam logic [1:0] DIV_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        DIV_IDLE = DIV_ST_IDLE,
        DIV_RUN  = DIV_ST_RUN,
        DIV_DONE = DIV_ST_DONE
    } div_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  src1;
        logic [3:0]  src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_to_ex_t;

    // Two's-complement negate when the flag is set
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// Iterative restoring divider: one quotient bit per cycle, signed fix-up on
// the outputs, divide-by-zero returns all-ones quotient and the dividend.
//
// state | meaning
// IDLE  | waiting; start captures operand magnitudes and requests stall
// RUN   | shift-subtract, one bit per cycle, stall requested
// DONE  | result valid; leaves when EX is allowed to advance
module ex_stage_div_unit
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic        i_hold,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_quo,
    output logic [31:0] o_rem
);

    localparam logic [4:0] CNT_LAST = 5'(DIV_CYCLES - 1);

    div_state_e  r_state;
    div_state_e  w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_div;
    logic [31:0] r_a_raw;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_b_zero;
    logic [32:0] w_rem_shift;
    logic        w_ge;
    logic [32:0] w_diff;

    assign w_rem_shift = {r_rem, r_quo[31]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_div});
    assign w_diff      = w_rem_shift - {1'b0, r_div};

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= DIV_IDLE;
        else     r_state <= w_next;
    end

    // Next state and stall/done flags
    always_comb begin
        w_next = r_state;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (i_start) begin
                    o_busy = 1'b1;
                    w_next = DIV_RUN;
                end
            end
            DIV_RUN: begin
                o_busy = 1'b1;
                if (r_cnt == CNT_LAST) w_next = DIV_DONE;
            end
            DIV_DONE: begin
                o_done = 1'b1;
                if (!i_hold) w_next = DIV_IDLE;
            end
            default: w_next = DIV_IDLE;
        endcase
    end

    // Operand capture and one shift-subtract step per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_a_raw  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (i_start) begin
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        r_quo    <= cond_neg(i_a, i_signed & i_a[31]);
                        r_div    <= cond_neg(i_b, i_signed & i_b[31]);
                        r_a_raw  <= i_a;
                        r_neg_q  <= i_signed & (i_a[31] ^ i_b[31]);
                        r_neg_r  <= i_signed & i_a[31];
                        r_b_zero <= (i_b == 32'd0);
                    end
                end
                DIV_RUN: begin
                    r_rem <= w_ge ? w_diff[31:0] : w_rem_shift[31:0];
                    r_quo <= {r_quo[30:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_quo = r_b_zero ? 32'hFFFF_FFFF : cond_neg(r_quo, r_neg_q);
    assign o_rem = r_b_zero ? r_a_raw       : cond_neg(r_rem, r_neg_r);

endmodule

// File: rtl/ex_stage.sv
// SimpleCPU execute stage: ID/EX pipeline register, operand muxes, one-hot
// ALU, data SRAM request, forwarding bus, HI/LO and the iterative divider.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
    output logic                    ex_is_load,
    output logic                    stallreq_for_ex,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    id_to_ex_t   r_id;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_ex_adv;
    logic        w_bubble;
    logic [5:0]  w_opcode;
    logic [5:0]  w_func;
    logic        w_special;
    logic        w_is_mfhi;
    logic        w_is_mflo;
    logic        w_is_mthi;
    logic        w_is_mtlo;
    logic        w_is_div;
    logic        w_is_divu;
    logic [31:0] w_sa_zext;
    logic [31:0] w_imm_sext;
    logic [31:0] w_imm_zext;
    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic [31:0] w_alu_res;
    logic [31:0] w_ex_result;
    logic        w_div_busy;
    logic        w_div_done;
    logic [31:0] w_div_quo;
    logic [31:0] w_div_rem;
    logic        w_unused;

    assign w_ex_adv = (stall[STALL_EX] == NO_STOP);
    assign w_bubble = (stall[STALL_EX] == STOP) && (stall[STALL_MEM] == NO_STOP);

    // ID/EX register: reset, bubble, load or hold
    always_ff @(posedge clk) begin
        if (rst)           r_id <= '0;
        else if (w_bubble) r_id <= '0;
        else if (w_ex_adv) r_id <= id_to_ex_bus;
    end

    assign w_opcode  = r_id.inst[31:26];
    assign w_func    = r_id.inst[5:0];
    assign w_special = (w_opcode == OPC_SPECIAL);
    assign w_is_mfhi = w_special && (w_func == FN_MFHI);
    assign w_is_mflo = w_special && (w_func == FN_MFLO);
    assign w_is_mthi = w_special && (w_func == FN_MTHI);
    assign w_is_mtlo = w_special && (w_func == FN_MTLO);
    assign w_is_div  = w_special && (w_func == FN_DIV);
    assign w_is_divu = w_special && (w_func == FN_DIVU);

    assign w_sa_zext  = {27'd0, r_id.inst[10:6]};
    assign w_imm_sext = {{16{r_id.inst[15]}}, r_id.inst[15:0]};
    assign w_imm_zext = {16'd0, r_id.inst[15:0]};

    // One-hot operand selects; an empty select yields zero
    always_comb begin
        w_src1 = ({32{r_id.src1[0]}} & r_id.rdata1)
               | ({32{r_id.src1[1]}} & r_id.pc)
               | ({32{r_id.src1[2]}} & w_sa_zext);
        w_src2 = ({32{r_id.src2[0]}} & r_id.rdata2)
               | ({32{r_id.src2[1]}} & w_imm_sext)
               | ({32{r_id.src2[2]}} & 32'd8)
               | ({32{r_id.src2[3]}} & w_imm_zext);
    end

    // One-hot ALU: each active op ORs its result in
    always_comb begin
        w_alu_res = '0;
        if (r_id.alu_op[ALU_ADD])  w_alu_res = w_alu_res | (w_src1 + w_src2);
        if (r_id.alu_op[ALU_SUB])  w_alu_res = w_alu_res | (w_src1 - w_src2);
        if (r_id.alu_op[ALU_SLT])  w_alu_res = w_alu_res | {31'd0, $signed(w_src1) < $signed(w_src2)};
        if (r_id.alu_op[ALU_SLTU]) w_alu_res = w_alu_res | {31'd0, w_src1 < w_src2};
        if (r_id.alu_op[ALU_AND])  w_alu_res = w_alu_res | (w_src1 & w_src2);
        if (r_id.alu_op[ALU_NOR])  w_alu_res = w_alu_res | ~(w_src1 | w_src2);
        if (r_id.alu_op[ALU_OR])   w_alu_res = w_alu_res | (w_src1 | w_src2);
        if (r_id.alu_op[ALU_XOR])  w_alu_res = w_alu_res | (w_src1 ^ w_src2);
        if (r_id.alu_op[ALU_SLL])  w_alu_res = w_alu_res | (w_src2 << w_src1[4:0]);
        if (r_id.alu_op[ALU_SRL])  w_alu_res = w_alu_res | (w_src2 >> w_src1[4:0]);
        if (r_id.alu_op[ALU_SRA])  w_alu_res = w_alu_res | 32'($signed(w_src2) >>> w_src1[4:0]);
        if (r_id.alu_op[ALU_LUI])  w_alu_res = w_alu_res | {w_src2[15:0], 16'd0};
    end

    // MFHI/MFLO override the ALU result
    always_comb begin
        w_ex_result = w_alu_res;
        if (w_is_mfhi)      w_ex_result = r_hi;
        else if (w_is_mflo) w_ex_result = r_lo;
    end

    // HI/LO: divider result on its exit edge, otherwise MTHI/MTLO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_ex_adv) begin
            if (w_div_done) begin
                r_hi <= w_div_rem;
                r_lo <= w_div_quo;
            end else if (w_is_mthi) begin
                r_hi <= r_id.rdata1;
            end else if (w_is_mtlo) begin
                r_lo <= r_id.rdata1;
            end
        end
    end

    ex_stage_div_unit #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_is_div | w_is_divu),
        .i_signed (w_is_div),
        .i_hold   (~w_ex_adv),
        .i_a      (r_id.rdata1),
        .i_b      (r_id.rdata2),
        .o_busy   (w_div_busy),
        .o_done   (w_div_done),
        .o_quo    (w_div_quo),
        .o_rem    (w_div_rem)
    );

    assign stallreq_for_ex = w_div_busy;
    assign ex_is_load      = r_id.ram_en & (r_id.ram_wen == 4'd0);

    assign data_sram_en    = r_id.ram_en;
    assign data_sram_wen   = r_id.ram_en ? r_id.ram_wen : 4'd0;
    assign data_sram_addr  = w_ex_result;
    assign data_sram_wdata = r_id.rdata2;

    assign ex_to_mem_bus = {r_id.pc, r_id.ram_en, r_id.ram_wen, r_id.sel_rf_res,
                            r_id.rf_we, r_id.rf_waddr, w_ex_result};
    assign ex_to_rf_bus  = {r_id.rf_we, r_id.rf_waddr, w_ex_result};

    assign w_unused = ^{stall[5:4], stall[1:0], r_id.inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with a minimal ctrl model for divider stalls.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [STALL_WD-1:0]     tb_stall;
    logic [STALL_WD-1:0]     stall;
    id_to_ex_t               bus;
    logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus;
    logic                    ex_is_load;
    logic                    stallreq_for_ex;
    logic                    data_sram_en;
    logic [3:0]              data_sram_wen;
    logic [31:0]             data_sram_addr;
    logic [31:0]             data_sram_wdata;

    int checks   = 0;
    int failures = 0;

    // ctrl holds IF/ID/EX/MEM-reg while the divider requests a stall
    assign stall        = tb_stall | (stallreq_for_ex ? 6'b001111 : 6'b000000);
    assign id_to_ex_bus = bus;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_rf_bus    (ex_to_rf_bus),
        .ex_is_load      (ex_is_load),
        .stallreq_for_ex (stallreq_for_ex),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic id_to_ex_t mk(input int op, input logic [2:0] s1, input logic [3:0] s2,
                                     input logic [31:0] inst, input logic [31:0] pc,
                                     input logic [31:0] rd1, input logic [31:0] rd2,
                                     input logic we, input logic [4:0] wa);
        id_to_ex_t b;
        b          = '0;
        b.alu_op   = (op < 0) ? 12'd0 : (12'd1 << op);
        b.src1     = s1;
        b.src2     = s2;
        b.inst     = inst;
        b.pc       = pc;
        b.rdata1   = rd1;
        b.rdata2   = rd2;
        b.rf_we    = we;
        b.rf_waddr = wa;
        return b;
    endfunction

    function automatic id_to_ex_t mk_special(input logic [5:0] fn, input logic [31:0] rd1,
                                             input logic [31:0] rd2, input logic we);
        return mk(-1, 3'b000, 4'b0000, {26'd0, fn}, 32'd0, rd1, rd2, we, 5'd2);
    endfunction

    task automatic wait_div(output int n, output bit timeout);
        n       = 0;
        timeout = 1'b0;
        while (stallreq_for_ex === 1'b1) begin
            n++;
            if (n > 200) begin
                timeout = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        tb_stall = '0;
        bus      = '0;
        step();
        step();
        rst = 1'b0;
        step();
        checks++; if (ex_to_mem_bus !== '0) begin failures++; $display("FAIL reset_mem_bus got=%h exp=0", ex_to_mem_bus); end
        checks++; if (ex_to_rf_bus !== '0) begin failures++; $display("FAIL reset_rf_bus got=%h exp=0", ex_to_rf_bus); end
        checks++; if (stallreq_for_ex !== 1'b0) begin failures++; $display("FAIL reset_stallreq got=%b exp=0", stallreq_for_ex); end
        checks++; if (ex_is_load !== 1'b0) begin failures++; $display("FAIL reset_is_load got=%b exp=0", ex_is_load); end
        checks++; if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== '0) begin
            failures++; $display("FAIL reset_sram got en=%b wen=%h addr=%h wdata=%h exp=0",
                                 data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
        end
    endtask

    task automatic test_addiu();
        bus = mk(ALU_ADD, 3'b001, 4'b0010, 32'h2403FFFF, 32'hBFC00000, 32'd5, 32'd0, 1'b1, 5'd3);
        step();
        checks++; if (ex_to_rf_bus !== {1'b1, 5'd3, 32'd4}) begin failures++; $display("FAIL addiu_rf_bus got=%h exp=%h", ex_to_rf_bus, {1'b1, 5'd3, 32'd4}); end
        checks++; if (ex_to_mem_bus[75:44] !== 32'hBFC00000) begin failures++; $display("FAIL addiu_pc got=%h exp=bfc00000", ex_to_mem_bus[75:44]); end
    endtask

    task automatic test_stall_bubble();
        // ori rt=4: 0xF0 | zext(0x000F) = 0xFF
        bus = mk(ALU_OR, 3'b001, 4'b1000, 32'h3404000F, 32'h0, 32'h000000F0, 32'd0, 1'b1, 5'd4);
        step();
        checks++; if (ex_to_rf_bus !== {1'b1, 5'd4, 32'hFF}) begin failures++; $display("FAIL ori_rf_bus got=%h exp=%h", ex_to_rf_bus, {1'b1, 5'd4, 32'hFF}); end
        bus      = mk(ALU_ADD, 3'b001, 4'b0010, 32'h2403FFFF, 32'h0, 32'd5, 32'd0, 1'b1, 5'd3);
        tb_stall = 6'b001100;
        step();
        checks++; if (ex_to_rf_bus !== {1'b1, 5'd4, 32'hFF}) begin failures++; $display("FAIL hold_rf_bus got=%h exp=%h", ex_to_rf_bus, {1'b1, 5'd4, 32'hFF}); end
        tb_stall = 6'b000100;
        step();
        checks++; if (ex_to_rf_bus[37] !== 1'b0) begin failures++; $display("FAIL bubble_rf_we got=%b exp=0", ex_to_rf_bus[37]); end
        checks++; if (data_sram_en !== 1'b0) begin failures++; $display("FAIL bubble_sram_en got=%b exp=0", data_sram_en); end
        tb_stall = '0;
        step();
        checks++; if (ex_to_rf_bus !== {1'b1, 5'd3, 32'd4}) begin failures++; $display("FAIL release_rf_bus got=%h exp=%h", ex_to_rf_bus, {1'b1, 5'd3, 32'd4}); end
    endtask

    task automatic test_alu();
        id_to_ex_t   b;
        logic [31:0] exp;
        for (int i = 0; i < 14; i++) begin
            case (i)
                0:  begin b = mk(ALU_SUB,  3'b001, 4'b0001, 32'h00000023, 0, 32'd10, 32'd3, 1, 5'd1);             exp = 32'd7;        end
                1:  begin b = mk(ALU_SLT,  3'b001, 4'b0001, 32'h0000002A, 0, 32'hFFFFFFFF, 32'd1, 1, 5'd1);       exp = 32'd1;        end
                2:  begin b = mk(ALU_SLTU, 3'b001, 4'b0001, 32'h0000002B, 0, 32'hFFFFFFFF, 32'd1, 1, 5'd1);       exp = 32'd0;        end
                3:  begin b = mk(ALU_AND,  3'b001, 4'b0001, 32'h00000024, 0, 32'hF0F0F0F0, 32'hFF00FF00, 1, 5'd1); exp = 32'hF000F000; end
                4:  begin b = mk(ALU_NOR,  3'b001, 4'b0001, 32'h00000027, 0, 32'hF0F0F0F0, 32'hFF00FF00, 1, 5'd1); exp = 32'h000F000F; end
                5:  begin b = mk(ALU_XOR,  3'b001, 4'b0001, 32'h00000026, 0, 32'hF0F0F0F0, 32'hFF00FF00, 1, 5'd1); exp = 32'h0FF00FF0; end
                6:  begin b = mk(ALU_SLL,  3'b100, 4'b0001, 32'h00000100, 0, 32'd0, 32'h000000FF, 1, 5'd1);       exp = 32'h00000FF0; end
                7:  begin b = mk(ALU_SRL,  3'b100, 4'b0001, 32'h00000102, 0, 32'd0, 32'h80000000, 1, 5'd1);       exp = 32'h08000000; end
                8:  begin b = mk(ALU_SRA,  3'b100, 4'b0001, 32'h00000103, 0, 32'd0, 32'h80000000, 1, 5'd1);       exp = 32'hF8000000; end
                9:  begin b = mk(ALU_SLL,  3'b001, 4'b0001, 32'h00000004, 0, 32'h24, 32'd1, 1, 5'd1);             exp = 32'h00000010; end
                10: begin b = mk(ALU_LUI,  3'b000, 4'b1000, 32'h3C011234, 0, 32'd0, 32'd0, 1, 5'd1);              exp = 32'h12340000; end
                11: begin b = mk(ALU_ADD,  3'b010, 4'b0100, 32'h0C000000, 32'hBFC00010, 32'd0, 32'd0, 1, 5'd31);  exp = 32'hBFC00018; end
                12: begin b = mk(ALU_ADD,  3'b000, 4'b0010, 32'h2400FFF0, 0, 32'd77, 32'd0, 1, 5'd1);             exp = 32'hFFFFFFF0; end
                default: begin b = mk(ALU_ADD, 3'b001, 4'b0001, 32'h00000021, 0, 32'hFFFFFFFF, 32'd2, 1, 5'd1);   exp = 32'd1;        end
            endcase
            bus = b;
            step();
            checks++;
            if (ex_to_rf_bus[31:0] !== exp) begin
                failures++;
                $display("FAIL alu_vec%0d got=%h exp=%h", i, ex_to_rf_bus[31:0], exp);
            end
        end
    endtask

    task automatic test_mem();
        id_to_ex_t b;
        b         = mk(ALU_ADD, 3'b001, 4'b0010, 32'hAC000008, 32'h0, 32'h100, 32'hDEADBEEF, 1'b0, 5'd0);
        b.ram_en  = 1'b1;
        b.ram_wen = 4'hF;
        bus = b;
        step();
        checks++; if (data_sram_addr !== 32'h108) begin failures++; $display("FAIL sw_addr got=%h exp=108", data_sram_addr); end
        checks++; if (data_sram_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", data_sram_wdata); end
        checks++; if ({data_sram_en, data_sram_wen} !== 5'h1F) begin failures++; $display("FAIL sw_en_wen got=%b/%h exp=1/f", data_sram_en, data_sram_wen); end
        checks++; if (ex_is_load !== 1'b0) begin failures++; $display("FAIL sw_is_load got=%b exp=0", ex_is_load); end
        b         = mk(ALU_ADD, 3'b001, 4'b0010, 32'h8C000004, 32'h0, 32'h200, 32'd0, 1'b1, 5'd6);
        b.ram_en  = 1'b1;
        b.ram_wen = 4'h0;
        bus = b;
        step();
        checks++; if (ex_is_load !== 1'b1) begin failures++; $display("FAIL lw_is_load got=%b exp=1", ex_is_load); end
        checks++; if (data_sram_addr !== 32'h204 || data_sram_en !== 1'b1 || data_sram_wen !== 4'h0) begin
            failures++; $display("FAIL lw_req got addr=%h en=%b wen=%h exp 204/1/0", data_sram_addr, data_sram_en, data_sram_wen);
        end
    endtask

    task automatic test_hilo_move();
        bus = mk_special(FN_MTHI, 32'h11112222, 32'd0, 1'b0);
        step();
        bus = mk_special(FN_MTLO, 32'h33334444, 32'd0, 1'b0);
        step();
        bus = mk_special(FN_MFHI, 32'd0, 32'd0, 1'b1);
        step();
        checks++; if (ex_to_rf_bus[31:0] !== 32'h11112222) begin failures++; $display("FAIL mfhi_after_mthi got=%h exp=11112222", ex_to_rf_bus[31:0]); end
        bus = mk_special(FN_MFLO, 32'd0, 32'd0, 1'b1);
        step();
        checks++; if (ex_to_rf_bus[31:0] !== 32'h33334444) begin failures++; $display("FAIL mflo_after_mtlo got=%h exp=33334444", ex_to_rf_bus[31:0]); end
    endtask

    task automatic test_div();
        int n;
        bit to;
        // DIV -7 / 2
        bus = mk_special(FN_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        step();
        bus = mk_special(FN_MFLO, 32'd0, 32'd0, 1'b1);
        wait_div(n, to);
        checks++; if (to || n != 33) begin failures++; $display("FAIL div_stall_cycles got=%0d timeout=%0b exp=33", n, to); end
        step();
        checks++; if (ex_to_rf_bus[31:0] !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", ex_to_rf_bus[31:0]); end
        bus = mk_special(FN_MFHI, 32'd0, 32'd0, 1'b1);
        step();
        checks++; if (ex_to_rf_bus[31:0] !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", ex_to_rf_bus[31:0]); end
        // DIVU 9 / 0, with DONE held by an external stall for two cycles
        bus = mk_special(FN_DIVU, 32'd9, 32'd0, 1'b0);
        step();
        bus = mk_special(FN_MFLO, 32'd0, 32'd0, 1'b1);
        wait_div(n, to);
        checks++; if (to || n != 33) begin failures++; $display("FAIL divu0_stall_cycles got=%0d timeout=%0b exp=33", n, to); end
        tb_stall = 6'b001100;
        step();
        step();
        checks++; if (stallreq_for_ex !== 1'b0) begin failures++; $display("FAIL done_hold_stallreq got=%b exp=0", stallreq_for_ex); end
        checks++; if (ex_to_rf_bus[37] !== 1'b0) begin failures++; $display("FAIL done_hold_instr got rf_we=%b exp=0", ex_to_rf_bus[37]); end
        tb_stall = '0;
        step();
        checks++; if (ex_to_rf_bus[31:0] !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu0_lo got=%h exp=ffffffff", ex_to_rf_bus[31:0]); end
        checks++; if (stallreq_for_ex !== 1'b0) begin failures++; $display("FAIL divu0_no_restart got=%b exp=0", stallreq_for_ex); end
        bus = mk_special(FN_MFHI, 32'd0, 32'd0, 1'b1);
        step();
        checks++; if (ex_to_rf_bus[31:0] !== 32'd9) begin failures++; $display("FAIL divu0_hi got=%h exp=9", ex_to_rf_bus[31:0]); end
    endtask

    task automatic test_reset_mid_div();
        int n;
        bit to;
        bus = mk_special(FN_DIVU, 32'd1000, 32'd3, 1'b0);
        step();
        bus = '0;
        for (int i = 0; i < 11; i++) step();
        checks++; if (stallreq_for_ex !== 1'b1) begin failures++; $display("FAIL run_stallreq got=%b exp=1", stallreq_for_ex); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (stallreq_for_ex !== 1'b0) begin failures++; $display("FAIL rst_run_stallreq got=%b exp=0", stallreq_for_ex); end
        checks++; if (ex_to_mem_bus !== '0) begin failures++; $display("FAIL rst_run_mem_bus got=%h exp=0", ex_to_mem_bus); end
        bus = mk_special(FN_MFLO, 32'd0, 32'd0, 1'b1);
        step();
        checks++; if (ex_to_rf_bus[31:0] !== 32'd0) begin failures++; $display("FAIL rst_lo got=%h exp=0", ex_to_rf_bus[31:0]); end
        bus = mk_special(FN_MFHI, 32'd0, 32'd0, 1'b1);
        step();
        checks++; if (ex_to_rf_bus[31:0] !== 32'd0) begin failures++; $display("FAIL rst_hi got=%h exp=0", ex_to_rf_bus[31:0]); end
        bus = mk_special(FN_DIVU, 32'd100, 32'd7, 1'b0);
        step();
        bus = mk_special(FN_MFLO, 32'd0, 32'd0, 1'b1);
        wait_div(n, to);
        checks++; if (to || n != 33) begin failures++; $display("FAIL divu_stall_cycles got=%0d timeout=%0b exp=33", n, to); end
        step();
        checks++; if (ex_to_rf_bus[31:0] !== 32'd14) begin failures++; $display("FAIL divu_lo got=%h exp=e", ex_to_rf_bus[31:0]); end
        bus = mk_special(FN_MFHI, 32'd0, 32'd0, 1'b1);
        step();
        checks++; if (ex_to_rf_bus[31:0] !== 32'd2) begin failures++; $display("FAIL divu_hi got=%h exp=2", ex_to_rf_bus[31:0]); end
    endtask

    initial begin
        test_reset();
        test_addiu();
        test_stall_bubble();
        test_alu();
        test_mem();
        test_hilo_move();
        test_div();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
